// File: rtl/posi_md_rd.sv
// Read-side sequencer for the intra-mode ping-pong buffer: streams one size level
// of stored modes in z-order through a 2-entry credit-managed output FIFO.
module posi_md_rd #(
    parameter int MD_W      = 6,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start_i,
    input  logic [1:0]      size_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            posi_md_ena_o,
    output logic [8:0]      posi_md_addr_o,
    input  logic [MD_W-1:0] posi_md_data_i,
    output logic            md_valid_o,
    input  logic            md_ready_i,
    output logic [MD_W-1:0] md_data_o,
    output logic [7:0]      md_idx_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      size_q, size_d;
    logic [8:0]      rd_cnt_q, rd_cnt_d;
    logic [8:0]      out_cnt_q, out_cnt_d;
    logic            inflight_q;
    logic [8:0]      addr_q;
    logic [1:0]      occ_q, occ_d;
    logic            wr_ptr_q, rd_ptr_q;

    logic            issue;
    logic            pop;
    logic            wr_en;
    logic [2:0]      used;
    logic [8:0]      base_w;
    logic [8:0]      count_w;
    logic [MD_W-1:0] entry_dat [BUF_DEPTH];

    // Address window and mode count of each size level inside the buffer.
    always_comb begin
        base_w  = 9'd84;
        count_w = 9'd256;
        case (size_q)
            2'd3: begin base_w = 9'd0;  count_w = 9'd4;  end
            2'd2: begin base_w = 9'd4;  count_w = 9'd16; end
            2'd1: begin base_w = 9'd20; count_w = 9'd64; end
            default: begin base_w = 9'd84; count_w = 9'd256; end
        endcase
    end

    assign wr_en      = inflight_q;
    assign md_valid_o = (occ_q != 2'd0);
    assign pop        = md_valid_o & md_ready_i;
    assign occ_d      = occ_q + {1'b0, wr_en} - {1'b0, pop};
    // Credits: FIFO entries plus the read in flight, minus the slot freed this cycle.
    assign used       = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q + {8'd0, pop};
        issue     = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    size_d    = size_i;
                    rd_cnt_d  = 9'd0;
                    out_cnt_d = 9'd0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (rd_cnt_q < count_w && used < 3'(BUF_DEPTH)) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 9'd1;
                    if (rd_cnt_q == count_w - 9'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && occ_d == 2'd0 && out_cnt_d == count_w) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign posi_md_ena_o  = issue;
    assign posi_md_addr_o = issue ? (base_w + rd_cnt_q) : addr_q;
    assign md_idx_o       = out_cnt_q[7:0];
    assign md_data_o      = entry_dat[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            size_q     <= 2'd0;
            rd_cnt_q   <= 9'd0;
            out_cnt_q  <= 9'd0;
            inflight_q <= 1'b0;
            addr_q     <= 9'd0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= issue;
            addr_q     <= posi_md_addr_o;
            occ_q      <= occ_d;
            if (wr_en) wr_ptr_q <= ~wr_ptr_q;
            if (pop)   rd_ptr_q <= ~rd_ptr_q;
        end
    end

    for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_fifo
        logic [MD_W-1:0] entry_q;
        always_ff @(posedge clk) begin
            if (!rstn) begin
                entry_q <= '0;
            end else if (wr_en && wr_ptr_q == 1'(gi)) begin
                entry_q <= posi_md_data_i;
            end
        end
        assign entry_dat[gi] = entry_q;
    end

endmodule

// File: tb/tb_posi_md_rd.sv
// Randomized bench for posi_md_rd: buffer RAM model, per-cycle stream monitor and
// directed timing, backpressure, restart and reset scenarios.
module tb_posi_md_rd;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_i;
    logic [1:0] size_i;
    logic       busy_o, done_o, posi_md_ena_o;
    logic [8:0] posi_md_addr_o;
    logic [5:0] posi_md_data_i = 6'd0;
    logic       md_valid_o, md_ready_i;
    logic [5:0] md_data_o;
    logic [7:0] md_idx_o;

    posi_md_rd #(.MD_W(6), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start_i),
        .size_i        (size_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .posi_md_ena_o (posi_md_ena_o),
        .posi_md_addr_o(posi_md_addr_o),
        .posi_md_data_i(posi_md_data_i),
        .md_valid_o    (md_valid_o),
        .md_ready_i    (md_ready_i),
        .md_data_o     (md_data_o),
        .md_idx_o      (md_idx_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Buffer contents: 4x4 entries fold onto the 8x8 window (base 20).
    function automatic logic [5:0] ram_val(input int a);
        int v;
        v = (a < 84) ? a : 20 + (a - 84) / 4;
        return v[5:0];
    endfunction

    always @(posedge clk)
        posi_md_data_i <= posi_md_ena_o ? ram_val(int'(posi_md_addr_o)) : 6'($urandom);

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // 0: ready held high, 1: random 50%, 2: ready held low
    int rdy_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       md_ready_i = 1'($urandom_range(0, 1));
            2:       md_ready_i = 1'b0;
            default: md_ready_i = 1'b1;
        endcase
    end

    logic       mon_en = 1'b0;
    logic       tmode  = 1'b0;
    int         start_edge, exp_base, exp_count;
    int         rd_seen, pop_seen, done_cnt, rel;
    logic       prev_stall;
    logic [5:0] prev_data;
    logic [7:0] prev_idx;

    always @(negedge clk) begin
        if (mon_en) begin
            rel = edge_cnt - start_edge;
            if (tmode) chk("busy", 32'(busy_o), 32'(rel >= 1 && rel <= exp_count + 3));
            if (prev_stall) begin
                chk("stall_valid", 32'(md_valid_o), 32'd1);
                chk("stall_data", 32'(md_data_o), 32'(prev_data));
                chk("stall_idx", 32'(md_idx_o), 32'(prev_idx));
            end
            if (posi_md_ena_o) begin
                chk("rd_in_range", 32'(rd_seen < exp_count), 32'd1);
                chk("rd_addr", 32'(posi_md_addr_o), 32'(exp_base + rd_seen));
                if (tmode) chk("rd_cycle", 32'(rel), 32'(rd_seen + 1));
                rd_seen++;
            end
            if (md_valid_o && md_ready_i) begin
                chk("out_idx", 32'(md_idx_o), 32'(pop_seen % 256));
                chk("out_data", 32'(md_data_o), 32'(ram_val(exp_base + pop_seen)));
                if (tmode) chk("pop_cycle", 32'(rel), 32'(pop_seen + 3));
                $display("mode idx=%0d data=%0d cycle=%0d", md_idx_o, md_data_o, rel);
                pop_seen++;
            end
            chk("outstanding", 32'((rd_seen - pop_seen) <= 2), 32'd1);
            if (done_o) begin
                if (tmode) chk("done_cycle", 32'(rel), 32'(exp_count + 3));
                chk("done_after_all", 32'(pop_seen), 32'(exp_count));
                done_cnt++;
            end
            prev_stall = md_valid_o && !md_ready_i;
            prev_data  = md_data_o;
            prev_idx   = md_idx_o;
        end
    end

    // Called at posedge+1; the current cycle becomes cycle 0.
    task automatic start_xfer(input logic [1:0] sz, input logic timed);
        case (sz)
            2'd3:    begin exp_base = 0;  exp_count = 4;   end
            2'd2:    begin exp_base = 4;  exp_count = 16;  end
            2'd1:    begin exp_base = 20; exp_count = 64;  end
            default: begin exp_base = 84; exp_count = 256; end
        endcase
        rd_seen    = 0;
        pop_seen   = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        tmode      = timed;
        start_edge = edge_cnt;
        mon_en     = 1'b1;
        start_i    = 1'b1;
        size_i     = sz;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_timeout", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic end_xfer();
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("reads_total", 32'(rd_seen), 32'(exp_count));
        chk("pops_total", 32'(pop_seen), 32'(exp_count));
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_valid", 32'(md_valid_o), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        int n;
        rstn       = 1'b0;
        start_i    = 1'b0;
        size_i     = 2'd0;
        md_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ena", 32'(posi_md_ena_o), 32'd0);
        chk("rst_addr", 32'(posi_md_addr_o), 32'd0);
        chk("rst_valid", 32'(md_valid_o), 32'd0);
        chk("rst_data", 32'(md_data_o), 32'd0);
        chk("rst_idx", 32'(md_idx_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 32x32 level, exact cycle timing
        start_xfer(2'd3, 1'b1);
        wait_done(50);
        end_xfer();

        // 8x8 level, done in cycle 67
        start_xfer(2'd1, 1'b1);
        wait_done(200);
        end_xfer();

        // 4x4 level with random backpressure
        rdy_mode = 1;
        start_xfer(2'd0, 1'b0);
        wait_done(3000);
        end_xfer();

        // Consumer stalled from the start, then released
        rdy_mode = 2;
        @(posedge clk);
        #1;
        start_xfer(2'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_reads", 32'(rd_seen), 32'd2);
        @(negedge clk);
        chk("stall_hold_valid", 32'(md_valid_o), 32'd1);
        chk("stall_hold_idx", 32'(md_idx_o), 32'd0);
        chk("stall_no_ena", 32'(posi_md_ena_o), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        wait_done(200);
        end_xfer();

        // Restart attempts mid-run and in the DONE cycle are ignored
        start_xfer(2'd2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        start_i = 1'b1;
        size_i  = 2'd0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("restart_done_seen", 32'(done_o), 32'd1);
        start_i = 1'b1;
        size_i  = 2'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        end_xfer();

        // Reset mid-run after 10 modes, then a clean 32x32 stream
        start_xfer(2'd0, 1'b0);
        n = 0;
        while (pop_seen < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_pops", 32'(pop_seen >= 10), 32'd1);
        mon_en = 1'b0;
        rstn   = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_ena", 32'(posi_md_ena_o), 32'd0);
        chk("mid_rst_addr", 32'(posi_md_addr_o), 32'd0);
        chk("mid_rst_valid", 32'(md_valid_o), 32'd0);
        chk("mid_rst_data", 32'(md_data_o), 32'd0);
        chk("mid_rst_idx", 32'(md_idx_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(posi_md_ena_o | md_valid_o | done_o), 32'd0);
        end
        @(posedge clk);
        #1;
        start_xfer(2'd3, 1'b1);
        wait_done(50);
        end_xfer();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
